// File: rtl/equiv_harness_pkg.sv
// rtl/equiv_harness_pkg.sv - shared types, constants and LFSR step for the equivalence stimulus harness
package equiv_harness_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [31:0] GOLDEN        = 32'h9E3779B9;
    localparam logic [31:0] DEF_LFSR_POLY = 32'h80200003;
    localparam logic [31:0] DEF_MISR_POLY = 32'h04C11DB7;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l, input logic [31:0] poly);
        return (l >> 1) ^ (l[0] ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/misr_fold.sv
// rtl/misr_fold.sv - folds a wide response word to SIG_W bits and shifts it into a MISR
module misr_fold
    import equiv_harness_pkg::*;
#(
    parameter int          IN_W  = 569,
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = DEF_MISR_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [IN_W-1:0]  y,
    output logic [SIG_W-1:0] sig
);

    localparam int NCH = (IN_W + SIG_W - 1) / SIG_W;
    localparam logic [SIG_W-1:0] POLY_S = SIG_W'(POLY);

    logic [NCH*SIG_W-1:0] pad;
    logic [SIG_W-1:0]     fold;

    // last chunk is zero-padded so every bit of y lands in exactly one chunk
    always_comb begin
        pad = '0;
        pad[IN_W-1:0] = y;
        fold = '0;
        for (int i = 0; i < NCH; i++) begin
            fold = fold ^ pad[i*SIG_W +: SIG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY_S : '0) ^ fold;
        end
    end

endmodule

// File: rtl/equiv_stim_harness.sv
// rtl/equiv_stim_harness.sv - LFSR stimulus, lock-step compare and MISR signatures for two DUT builds
module equiv_stim_harness
    import equiv_harness_pkg::*;
#(
    parameter int          IN_W      = 64,
    parameter int          OUT_W     = 569,
    parameter int          LAT       = 1,
    parameter int          SIG_W     = 32,
    parameter logic [31:0] LFSR_POLY = DEF_LFSR_POLY,
    parameter logic [31:0] MISR_POLY = DEF_MISR_POLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      vec_count,
    input  logic [31:0]      seed,
    output logic [IN_W-1:0]  stim,
    output logic             stim_valid,
    input  logic [OUT_W-1:0] y_a,
    input  logic [OUT_W-1:0] y_b,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [15:0]      first_mm_idx,
    output logic [SIG_W-1:0] sig_a,
    output logic [SIG_W-1:0] sig_b
);

    localparam int NW = (IN_W + 31) / 32;
    localparam int DW = $clog2(LAT + 1);

    function automatic logic [IN_W-1:0] expand(input logic [31:0] l);
        logic [NW*32-1:0] w;
        logic [31:0]      k;
        k = '0;
        for (int i = 0; i < NW; i++) begin
            w[32*i +: 32] = l ^ k;
            k = k + GOLDEN;
        end
        return w[IN_W-1:0];
    endfunction

    state_t          state, state_nxt;
    logic [31:0]     lfsr;
    logic [31:0]     seed_eff;
    logic [15:0]     count_q;
    logic [15:0]     issued;
    logic [15:0]     stim_idx;
    logic [DW-1:0]   drain_cnt;
    logic [LAT-1:0]  dv_q;
    logic [LAT*16-1:0] didx_q;
    logic            start_acc;
    logic            last_issued;
    logic            resp_valid;
    logic [15:0]     resp_idx;

    assign seed_eff    = (seed == 32'h0) ? 32'h1 : seed;
    assign start_acc   = start && (state == IDLE);
    assign last_issued = (issued == count_q);
    assign resp_valid  = dv_q[LAT-1];
    assign resp_idx    = didx_q[LAT*16-1 -: 16];
    assign busy        = (state != IDLE);
    assign done        = (state == FINISH);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // an empty run still passes through DRAIN so done keeps the start+count+LAT+1 timing
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (vec_count != 16'h0) ? RUN : DRAIN;
            RUN:     if (last_issued) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DW'(LAT - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr       <= 32'h1;
            stim       <= '0;
            stim_valid <= 1'b0;
            stim_idx   <= '0;
            issued     <= '0;
            count_q    <= '0;
            drain_cnt  <= '0;
            dv_q       <= '0;
            didx_q     <= '0;
        end else begin
            if (start_acc) begin
                count_q <= vec_count;
                if (vec_count != 16'h0) begin
                    stim       <= expand(seed_eff);
                    stim_valid <= 1'b1;
                    stim_idx   <= '0;
                    issued     <= 16'h1;
                    lfsr       <= lfsr_step(seed_eff, LFSR_POLY);
                end else begin
                    stim_valid <= 1'b0;
                    issued     <= '0;
                    lfsr       <= seed_eff;
                end
            end else if (state == RUN && !last_issued) begin
                stim       <= expand(lfsr);
                stim_valid <= 1'b1;
                stim_idx   <= issued;
                issued     <= issued + 16'h1;
                lfsr       <= lfsr_step(lfsr, LFSR_POLY);
            end else begin
                stim_valid <= 1'b0;
            end

            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            // response of a vector arrives LAT cycles after it sits on stim
            dv_q   <= LAT'({dv_q, stim_valid});
            didx_q <= (LAT*16)'({didx_q, stim_idx});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch     <= 1'b0;
            first_mm_idx <= '0;
        end else if (start_acc) begin
            mismatch     <= 1'b0;
            first_mm_idx <= '0;
        end else if (resp_valid && !mismatch && (y_a != y_b)) begin
            mismatch     <= 1'b1;
            first_mm_idx <= resp_idx;
        end
    end

    misr_fold #(.IN_W(OUT_W), .SIG_W(SIG_W), .POLY(MISR_POLY)) u_misr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .en    (resp_valid),
        .y     (y_a),
        .sig   (sig_a)
    );

    misr_fold #(.IN_W(OUT_W), .SIG_W(SIG_W), .POLY(MISR_POLY)) u_misr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_acc),
        .en    (resp_valid),
        .y     (y_b),
        .sig   (sig_b)
    );

endmodule

// File: tb/tb_equiv_stim_harness.sv
// tb/tb_equiv_stim_harness.sv - directed bench for equiv_stim_harness with registered-stim DUT model
module tb_equiv_stim_harness;

    localparam int IN_W  = 64;
    localparam int OUT_W = 569;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      vec_count = '0;
    logic [31:0]      seed = '0;
    logic [IN_W-1:0]  stim;
    logic             stim_valid;
    logic [OUT_W-1:0] y_a = '0;
    logic [OUT_W-1:0] y_b = '0;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [15:0]      first_mm_idx;
    logic [31:0]      sig_a;
    logic [31:0]      sig_b;

    logic             fault_en = 1'b0;
    logic [31:0]      fault_word = '0;

    int n_cmp = 0;
    int n_bad = 0;

    equiv_stim_harness dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vec_count    (vec_count),
        .seed         (seed),
        .stim         (stim),
        .stim_valid   (stim_valid),
        .y_a          (y_a),
        .y_b          (y_b),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .first_mm_idx (first_mm_idx),
        .sig_a        (sig_a),
        .sig_b        (sig_b)
    );

    always #5 clk = ~clk;

    // two LAT=1 DUT builds; B optionally has bit 0 flipped for one chosen vector
    always @(posedge clk) begin
        y_a <= OUT_W'(stim);
        y_b <= OUT_W'(stim) ^ OUT_W'(fault_en && stim_valid && (stim[31:0] == fault_word));
    end

    function automatic logic [31:0] lfsr_at(input logic [31:0] sd, input int k);
        logic [31:0] l;
        l = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        return l;
    endfunction

    function automatic logic [31:0] ref_sig(input logic [31:0] sd, input int cnt, input int fk);
        logic [31:0]      l, s, f;
        logic [OUT_W-1:0] y;
        l = (sd == 32'h0) ? 32'h1 : sd;
        s = 32'h0;
        for (int k = 0; k < cnt; k++) begin
            y = '0;
            y[31:0]  = l;
            y[63:32] = l ^ 32'h9E3779B9;
            if (k == fk) y[0] = ~y[0];
            f = 32'h0;
            for (int j = 0; j < OUT_W; j++) f[j % 32] = f[j % 32] ^ y[j];
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] cnt, input logic [31:0] sd);
        vec_count = cnt;
        seed      = sd;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    // cyc counts cycles after the start edge; -1 means done never came
    task automatic wait_done(input int extra_start_at, output int cyc, output int nval);
        cyc  = 1;
        nval = stim_valid ? 1 : 0;
        while (!done && cyc < 2000) begin
            if (cyc == extra_start_at) begin
                start     = 1'b1;
                vec_count = 16'd5;
                seed      = 32'd77;
            end
            tick();
            start = 1'b0;
            cyc++;
            if (stim_valid) nval++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        vec_count = 16'd4;
        seed = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy);
            end
        end
        n_cmp++;
        if ({stim, stim_valid, done, mismatch, first_mm_idx, sig_a, sig_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got stim=%h v=%b d=%b mm=%b idx=%h sa=%h sb=%h want all 0",
                     stim, stim_valid, done, mismatch, first_mm_idx, sig_a, sig_b);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_identical();
        int cyc, nval;
        launch(16'd20, 32'h1);
        wait_done(-1, cyc, nval);
        n_cmp++;
        if (cyc !== 22) begin n_bad++; $display("FAIL ident_done_cycle: got %0d want 22", cyc); end
        n_cmp++;
        if (nval !== 20) begin n_bad++; $display("FAIL ident_nvec: got %0d want 20", nval); end
        n_cmp++;
        if (mismatch !== 1'b0) begin n_bad++; $display("FAIL ident_mismatch: got %b want 0", mismatch); end
        n_cmp++;
        if (sig_a !== ref_sig(32'h1, 20, -1)) begin
            n_bad++; $display("FAIL ident_sig_a: got %h want %h", sig_a, ref_sig(32'h1, 20, -1));
        end
        n_cmp++;
        if (sig_b !== ref_sig(32'h1, 20, -1)) begin
            n_bad++; $display("FAIL ident_sig_b: got %h want %h", sig_b, ref_sig(32'h1, 20, -1));
        end
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL ident_idle_after: got %b want 00", {busy, done}); end
    endtask

    task automatic test_fault();
        int cyc, nval;
        fault_word = lfsr_at(32'h1, 7);
        fault_en   = 1'b1;
        launch(16'd20, 32'h1);
        wait_done(-1, cyc, nval);
        fault_en   = 1'b0;
        n_cmp++;
        if (mismatch !== 1'b1) begin n_bad++; $display("FAIL fault_mismatch: got %b want 1", mismatch); end
        n_cmp++;
        if (first_mm_idx !== 16'd7) begin n_bad++; $display("FAIL fault_idx: got %0d want 7", first_mm_idx); end
        n_cmp++;
        if (sig_a !== ref_sig(32'h1, 20, -1)) begin
            n_bad++; $display("FAIL fault_sig_a: got %h want %h", sig_a, ref_sig(32'h1, 20, -1));
        end
        n_cmp++;
        if (sig_b !== ref_sig(32'h1, 20, 7)) begin
            n_bad++; $display("FAIL fault_sig_b: got %h want %h", sig_b, ref_sig(32'h1, 20, 7));
        end
        tick();
    endtask

    task automatic test_zero_count();
        int cyc, nval;
        launch(16'd0, 32'h5);
        wait_done(-1, cyc, nval);
        n_cmp++;
        if (cyc !== 2) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 2", cyc); end
        n_cmp++;
        if (nval !== 0) begin n_bad++; $display("FAIL zero_nvec: got %0d want 0", nval); end
        n_cmp++;
        if ({mismatch, sig_a, sig_b} !== '0) begin
            n_bad++; $display("FAIL zero_clear: got mm=%b sa=%h sb=%h want 0", mismatch, sig_a, sig_b);
        end
        tick();
        launch(16'd3, 32'h0);
        n_cmp++;
        if (stim !== {32'h9E3779B8, 32'h00000001} || stim_valid !== 1'b1) begin
            n_bad++; $display("FAIL zero_seed_stim: got %h v=%b want 9e3779b800000001 v=1", stim, stim_valid);
        end
        wait_done(-1, cyc, nval);
        n_cmp++;
        if (sig_a !== ref_sig(32'h1, 3, -1)) begin
            n_bad++; $display("FAIL zero_seed_sig: got %h want %h", sig_a, ref_sig(32'h1, 3, -1));
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, nval;
        launch(16'd20, 32'h1);
        wait_done(5, cyc, nval);
        n_cmp++;
        if (cyc !== 22) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 22", cyc); end
        n_cmp++;
        if (nval !== 20) begin n_bad++; $display("FAIL b2b_nvec: got %0d want 20", nval); end
        n_cmp++;
        if (sig_a !== ref_sig(32'h1, 20, -1)) begin
            n_bad++; $display("FAIL b2b_sig_a: got %h want %h", sig_a, ref_sig(32'h1, 20, -1));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_on_done: got busy=%b want 0", busy); end
        tick();
        n_cmp++;
        if ({busy, stim_valid} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_stays_idle: got %b want 00", {busy, stim_valid});
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, nval;
        int saw_done;
        saw_done = 0;
        launch(16'd20, 32'h1234);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({stim, stim_valid, busy, done, mismatch, first_mm_idx, sig_a, sig_b} !== '0) begin
            n_bad++; $display("FAIL midrst_outputs: got stim=%h v=%b b=%b d=%b sa=%h want all 0",
                              stim, stim_valid, busy, done, sig_a);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) saw_done = 1;
        end
        n_cmp++;
        if (saw_done !== 0) begin n_bad++; $display("FAIL midrst_no_done: got activity=%0d want 0", saw_done); end
        launch(16'd20, 32'h1);
        n_cmp++;
        if (stim[31:0] !== 32'h1) begin n_bad++; $display("FAIL midrst_restart_stim: got %h want 00000001", stim[31:0]); end
        wait_done(-1, cyc, nval);
        n_cmp++;
        if (cyc !== 22 || sig_b !== ref_sig(32'h1, 20, -1)) begin
            n_bad++; $display("FAIL midrst_rerun: got cyc=%0d sig=%h want 22 %h", cyc, sig_b, ref_sig(32'h1, 20, -1));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_identical();
        test_fault();
        test_zero_count();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
